// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter/sequencer that shares one SPI
// controller between NUM_REQ requesters.
//
// Ports:
//   axi_clk, reset_b      clock, async active-low reset
//   req_valid/wnr/addr/len per-requester header, requester i in slice i
//   req_ack               one-hot grant, handshake = req_valid & req_ack
//   req_done, req_timeout end-of-transaction pulse (+ watchdog abort flag)
//   WnR, spi_address,
//   spi_data_len, spi_done SPI controller interface
//   grant_id, busy        current/last winner, not-IDLE indicator
//
// Optional: define SPI_ARB_TIMEOUT_EN to add a RUN-state watchdog of
// TIMEOUT_CYCLES cycles; otherwise RUN waits for spi_done indefinitely.

module spi_txn_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       axi_clk,
    input  logic                       reset_b,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_wnr,
    input  logic [10*NUM_REQ-1:0]      req_addr,
    input  logic [8*NUM_REQ-1:0]       req_len,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [NUM_REQ-1:0]         req_done,
    output logic                       req_timeout,
    output logic                       WnR,
    output logic [9:0]                 spi_address,
    output logic [7:0]                 spi_data_len,
    input  logic                       spi_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IW:0]   NR       = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] PTR_RST  = IW'(NUM_REQ - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [IW-1:0] ptr_q;
    logic [GW-1:0] gap_cnt;

    logic          found;
    logic [IW-1:0] winner;
    logic [IW:0]   cand;
    logic          hs;
    logic          win_wnr;
    logic [9:0]    win_addr;
    logic [7:0]    win_len;

    logic          run_end;
    logic          to_flag;
    logic          timeout_hit;

    // Round-robin search starting just after the last winner.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= NR) begin
                cand = cand - NR;
            end
            if (!found && req_valid[cand[IW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IW-1:0];
            end
        end
    end

    // Ack is gated by reset so every output reads 0 while reset is held.
    assign hs       = reset_b && (state_q == IDLE) && found;
    assign win_wnr  = req_wnr[winner];
    assign win_addr = req_addr[int'(winner)*10 +: 10];
    assign win_len  = req_len[int'(winner)*8 +: 8];

    always_comb begin
        req_ack = '0;
        if (hs) begin
            req_ack[winner] = 1'b1;
        end
    end

    assign busy = (state_q != IDLE);

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Counts RUN cycles already elapsed; zero on the first RUN cycle.
    logic [TW-1:0] to_cnt;

    always_ff @(posedge axi_clk or negedge reset_b) begin
        if (!reset_b) begin
            to_cnt <= '0;
        end else if (state_q == RUN) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign timeout_hit = (state_q == RUN) && (to_cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        run_end = 1'b0;
        to_flag = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = (win_len == 8'd0) ? GAP : RUN;
                end
            end
            RUN: begin
                // spi_done takes precedence over a coincident timeout.
                if (spi_done || timeout_hit) begin
                    state_d = GAP;
                    run_end = 1'b1;
                    to_flag = !spi_done;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge axi_clk or negedge reset_b) begin
        if (!reset_b) begin
            ptr_q        <= PTR_RST;
            grant_id     <= '0;
            WnR          <= 1'b0;
            spi_address  <= '0;
            spi_data_len <= '0;
            req_done     <= '0;
            req_timeout  <= 1'b0;
            gap_cnt      <= '0;
        end else begin
            req_done    <= '0;
            req_timeout <= 1'b0;
            gap_cnt     <= (state_q == GAP) ? gap_cnt + 1'b1 : '0;
            if (hs) begin
                WnR          <= win_wnr;
                spi_address  <= win_addr;
                spi_data_len <= win_len;
                grant_id     <= winner;
                ptr_q        <= winner;
                // Zero-length request completes without touching SPI.
                if (win_len == 8'd0) begin
                    req_done[winner] <= 1'b1;
                end
            end
            if (run_end) begin
                spi_data_len       <= '0;
                req_done[grant_id] <= 1'b1;
                req_timeout        <= to_flag;
            end
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed self-checking bench for spi_txn_arbiter
// (NUM_REQ=2, GAP_CYCLES=1, TIMEOUT_CYCLES=16).

module tb_spi_txn_arbiter;

    logic        axi_clk = 1'b0;
    logic        reset_b = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_wnr = '0;
    logic [19:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic [1:0]  req_ack;
    logic [1:0]  req_done;
    logic        req_timeout;
    logic        WnR;
    logic [9:0]  spi_address;
    logic [7:0]  spi_data_len;
    logic        spi_done = 1'b0;
    logic [0:0]  grant_id;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    spi_txn_arbiter #(
        .NUM_REQ(2),
        .GAP_CYCLES(1),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .axi_clk(axi_clk),
        .reset_b(reset_b),
        .req_valid(req_valid),
        .req_wnr(req_wnr),
        .req_addr(req_addr),
        .req_len(req_len),
        .req_ack(req_ack),
        .req_done(req_done),
        .req_timeout(req_timeout),
        .WnR(WnR),
        .spi_address(spi_address),
        .spi_data_len(spi_data_len),
        .spi_done(spi_done),
        .grant_id(grant_id),
        .busy(busy)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic tick;
        @(posedge axi_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [9:0] a, input logic [7:0] l);
        req_valid[i]        = v;
        req_wnr[i]          = w;
        req_addr[i*10 +: 10] = a;
        req_len[i*8 +: 8]    = l;
    endtask

    task automatic test_reset;
        reset_b = 1'b0;
        #2;
        total_cnt++;
        if ({req_ack, req_done, req_timeout, WnR} !== 6'b0)
            $display("FAIL rst_ctl got %b want 0",
                     {req_ack, req_done, req_timeout, WnR});
        else pass_cnt++;
        total_cnt++;
        if ({spi_address, spi_data_len, grant_id, busy} !== 20'b0)
            $display("FAIL rst_bus got %h want 0",
                     {spi_address, spi_data_len, grant_id, busy});
        else pass_cnt++;
        tick;
        reset_b = 1'b1;
        tick;
    endtask

    task automatic test_single_write;
        set_req(0, 1'b1, 1'b1, 10'h155, 8'd40);
        #1;
        total_cnt++;
        if (req_ack !== 2'b01)
            $display("FAIL sw_ack got %b want 01", req_ack);
        else pass_cnt++;
        tick;
        // fields may change after the handshake without effect
        set_req(0, 1'b0, 1'b0, 10'h2AA, 8'd7);
        total_cnt++;
        if ({WnR, spi_address, spi_data_len} !== {1'b1, 10'h155, 8'd40})
            $display("FAIL sw_hdr got %b/%h/%0d want 1/155/40",
                     WnR, spi_address, spi_data_len);
        else pass_cnt++;
        total_cnt++;
        if ({busy, grant_id, req_ack} !== 4'b1000)
            $display("FAIL sw_run got %b want 1000",
                     {busy, grant_id, req_ack});
        else pass_cnt++;
        tick;
        tick;
        total_cnt++;
        if (spi_data_len !== 8'd40)
            $display("FAIL sw_hold got %0d want 40", spi_data_len);
        else pass_cnt++;
        spi_done = 1'b1;
        tick;
        spi_done = 1'b0;
        total_cnt++;
        if ({spi_data_len, req_done, req_timeout, busy} !== {8'd0, 2'b01, 1'b0, 1'b1})
            $display("FAIL sw_done got %0d/%b/%b/%b want 0/01/0/1",
                     spi_data_len, req_done, req_timeout, busy);
        else pass_cnt++;
        total_cnt++;
        if ({WnR, spi_address} !== {1'b1, 10'h155})
            $display("FAIL sw_gap_hold got %b/%h want 1/155", WnR, spi_address);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({busy, req_done} !== 3'b000)
            $display("FAIL sw_idle got %b want 000", {busy, req_done});
        else pass_cnt++;
    endtask

    task automatic test_contention;
        logic [1:0] exp_ack;
        logic [9:0] exp_addr;
        logic       two_hot;
        int         w;
        reset_b = 1'b0;
        tick;
        reset_b = 1'b1;
        two_hot = 1'b0;
        set_req(0, 1'b1, 1'b1, 10'h011, 8'd8);
        set_req(1, 1'b1, 1'b0, 10'h322, 8'd16);
        for (int t = 0; t < 4; t++) begin
            exp_ack  = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (t % 2 == 0) ? 10'h011 : 10'h322;
            w = 0;
            #1;
            while (req_ack == 2'b00 && w < 20) begin
                tick;
                w++;
                if ($countones(req_ack) > 1) two_hot = 1'b1;
            end
            if ($countones(req_ack) > 1) two_hot = 1'b1;
            total_cnt++;
            if (req_ack !== exp_ack)
                $display("FAIL cont_ack[%0d] got %b want %b", t, req_ack, exp_ack);
            else pass_cnt++;
            tick;
            total_cnt++;
            if ({grant_id, spi_address} !== {exp_ack[1], exp_addr})
                $display("FAIL cont_grant[%0d] got %b/%h want %b/%h",
                         t, grant_id, spi_address, exp_ack[1], exp_addr);
            else pass_cnt++;
            tick;
            spi_done = 1'b1;
            tick;
            spi_done = 1'b0;
            total_cnt++;
            if (req_done !== exp_ack)
                $display("FAIL cont_done[%0d] got %b want %b", t, req_done, exp_ack);
            else pass_cnt++;
            tick;
        end
        req_valid = 2'b00;
        total_cnt++;
        if (two_hot !== 1'b0)
            $display("FAIL cont_onehot got two-hot ack want one-hot");
        else pass_cnt++;
        tick;
    endtask

    task automatic test_zero_len;
        set_req(1, 1'b1, 1'b1, 10'h0C3, 8'd0);
        #1;
        total_cnt++;
        if (req_ack !== 2'b10)
            $display("FAIL zl_ack got %b want 10", req_ack);
        else pass_cnt++;
        tick;
        set_req(1, 1'b0, 1'b0, 10'h000, 8'd0);
        set_req(0, 1'b1, 1'b0, 10'h0AA, 8'd24);
        total_cnt++;
        if ({spi_data_len, req_done, busy} !== {8'd0, 2'b10, 1'b1})
            $display("FAIL zl_done got %0d/%b/%b want 0/10/1",
                     spi_data_len, req_done, busy);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({busy, req_done, req_ack} !== 5'b00001)
            $display("FAIL zl_next got %b want 00001", {busy, req_done, req_ack});
        else pass_cnt++;
        tick;
        set_req(0, 1'b0, 1'b0, 10'h000, 8'd0);
        total_cnt++;
        if ({spi_address, spi_data_len} !== {10'h0AA, 8'd24})
            $display("FAIL zl_serve got %h/%0d want 0aa/24",
                     spi_address, spi_data_len);
        else pass_cnt++;
        spi_done = 1'b1;
        tick;
        spi_done = 1'b0;
        tick;
    endtask

    task automatic test_stray_done;
        spi_done = 1'b1;
        tick;
        spi_done = 1'b0;
        total_cnt++;
        if ({busy, req_done} !== 3'b000)
            $display("FAIL stray_idle got %b want 000", {busy, req_done});
        else pass_cnt++;
        set_req(0, 1'b1, 1'b0, 10'h005, 8'd0);
        tick;
        set_req(0, 1'b0, 1'b0, 10'h000, 8'd0);
        spi_done = 1'b1;
        tick;
        spi_done = 1'b0;
        total_cnt++;
        if ({busy, req_done, spi_data_len} !== {3'b000, 8'd0})
            $display("FAIL stray_gap got %b/%0d want 000/0",
                     {busy, req_done}, spi_data_len);
        else pass_cnt++;
        // withdrawn request: valid drops before the edge
        set_req(1, 1'b1, 1'b1, 10'h111, 8'd5);
        #2;
        set_req(1, 1'b0, 1'b1, 10'h111, 8'd5);
        tick;
        total_cnt++;
        if ({busy, spi_data_len} !== {1'b0, 8'd0})
            $display("FAIL withdraw got %b/%0d want 0/0", busy, spi_data_len);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run;
        set_req(0, 1'b1, 1'b0, 10'h100, 8'd200);
        tick;
        set_req(0, 1'b0, 1'b0, 10'h000, 8'd0);
        set_req(1, 1'b1, 1'b1, 10'h3FF, 8'd9);
        tick;
        total_cnt++;
        if ({spi_data_len, req_ack} !== {8'd200, 2'b00})
            $display("FAIL rmr_run got %0d/%b want 200/00", spi_data_len, req_ack);
        else pass_cnt++;
        #2;
        reset_b = 1'b0;
        #1;
        total_cnt++;
        if ({spi_data_len, busy, req_ack} !== {8'd0, 3'b000})
            $display("FAIL rmr_async got %0d/%b/%b want 0/0/00",
                     spi_data_len, busy, req_ack);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (req_done !== 2'b00)
            $display("FAIL rmr_nodone got %b want 00", req_done);
        else pass_cnt++;
        set_req(0, 1'b1, 1'b0, 10'h0F0, 8'd3);
        reset_b = 1'b1;
        #1;
        total_cnt++;
        if (req_ack !== 2'b01)
            $display("FAIL rmr_first got %b want 01", req_ack);
        else pass_cnt++;
        tick;
        req_valid = 2'b00;
        total_cnt++;
        if ({grant_id, spi_data_len} !== {1'b0, 8'd3})
            $display("FAIL rmr_serve got %b/%0d want 0/3", grant_id, spi_data_len);
        else pass_cnt++;
        spi_done = 1'b1;
        tick;
        spi_done = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        set_req(1, 1'b1, 1'b1, 10'h2C0, 8'd50);
        tick;
        req_valid = 2'b00;
`ifdef SPI_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick;
        total_cnt++;
        if (spi_data_len !== 8'd50)
            $display("FAIL to_c16 got %0d want 50", spi_data_len);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({spi_data_len, req_done, req_timeout} !== {8'd0, 2'b10, 1'b1})
            $display("FAIL to_fire got %0d/%b/%b want 0/10/1",
                     spi_data_len, req_done, req_timeout);
        else pass_cnt++;
        tick;
        set_req(1, 1'b1, 1'b1, 10'h2C0, 8'd50);
        tick;
        req_valid = 2'b00;
        for (int i = 0; i < 15; i++) tick;
        spi_done = 1'b1;
        tick;
        spi_done = 1'b0;
        total_cnt++;
        if ({spi_data_len, req_done, req_timeout} !== {8'd0, 2'b10, 1'b0})
            $display("FAIL to_tie got %0d/%b/%b want 0/10/0",
                     spi_data_len, req_done, req_timeout);
        else pass_cnt++;
        tick;
`else
        for (int i = 0; i < 20; i++) tick;
        total_cnt++;
        if ({spi_data_len, busy, req_timeout, req_done} !== {8'd50, 4'b1000})
            $display("FAIL nto_wait got %0d/%b want 50/1000",
                     spi_data_len, {busy, req_timeout, req_done});
        else pass_cnt++;
        spi_done = 1'b1;
        tick;
        spi_done = 1'b0;
        total_cnt++;
        if ({req_done, req_timeout} !== 3'b100)
            $display("FAIL nto_done got %b want 100", {req_done, req_timeout});
        else pass_cnt++;
        tick;
`endif
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_contention;
        test_zero_len;
        test_stray_done;
        test_reset_mid_run;
        test_timeout;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Round-robin arbiter and sequencer sharing the single SP3 SPI controller between NUM_REQ requesters, e.g. the AXI software path and an autonomous register-poll engine.
- Per transaction it latches the winning requester's header (WnR, address, length) and drives it to the SPI controller. It holds spi_data_len non-zero until the controller's done pulse, then forces spi_data_len to 0 so the controller parks in IDLE.
- Command and read FIFOs stay with the requesters. The granted requester must preload write data before raising valid.

Parameters:
NUM_REQ, 2, number of requesters (>=2); per-requester buses are flattened, requester i in slice i
GAP_CYCLES, 1, cycles spi_data_len is held at 0 between transactions (>=1)
TIMEOUT_CYCLES, 4096, watchdog limit in RUN (used only with SPI_ARB_TIMEOUT_EN)

Ports:
axi_clk  in  1  clock
reset_b  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  requester i has a transaction pending
req_wnr  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  10*NUM_REQ  SPI register address, per requester
req_len  in  8*NUM_REQ  transaction length in bits, per requester
req_ack  out  NUM_REQ  one-hot; handshake completes on req_valid[i]&req_ack[i]
req_done  out  NUM_REQ  one-cycle pulse; requester i's transaction finished
req_timeout  out  1  qualifies req_done: transaction aborted by watchdog
WnR  out  1  to SPI controller
spi_address  out  10  to SPI controller
spi_data_len  out  8  to SPI controller; non-zero starts a transaction
spi_done  in  1  done pulse from SPI controller
grant_id  out  $clog2(NUM_REQ)  index of current or last granted requester
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE; all outputs 0; rr pointer = NUM_REQ-1, so requester 0 wins first; counters 0.
- States: IDLE, RUN, GAP, with transitions below.
- IDLE:
  - Winner = first i with req_valid[i], searching from pointer+1 modulo NUM_REQ.
  - req_ack[winner] is asserted combinationally in the same cycle; at most one ack bit is ever high; no ack outside IDLE.
  - On handshake edge: latch req_wnr/addr/len of winner into WnR/spi_address/spi_data_len registers; grant_id and pointer <= winner.
  - If latched len != 0: go to RUN. The controller sees non-zero spi_data_len the cycle after the handshake.
  - If latched len == 0: go to GAP; req_done[winner] pulses on the next cycle; no SPI activity.
- RUN:
  - WnR, spi_address and spi_data_len stay stable; the controller samples them live.
  - On a cycle with spi_done=1, the next edge sets spi_data_len <= 0, state <= GAP, and req_done[grant_id] = 1 for exactly that first GAP cycle.
  - Zero-cycle turnaround is required: the controller re-enters IDLE on the same edge and must see len=0.
- GAP: spi_data_len = 0 for GAP_CYCLES cycles, then return to IDLE. WnR and spi_address hold their last values.
- spi_done outside RUN is ignored.
- Requester fields may change freely after the handshake without effect.
- Deasserting req_valid before ack withdraws the request; nothing is latched.
- Fairness: a requester with valid continuously high is granted within NUM_REQ transactions.
- Back-to-back: minimum spacing between transactions is 1 handshake cycle + GAP_CYCLES.
- Reset mid-RUN: spi_data_len drops to 0 asynchronously, which aborts the controller. No req_done is issued.

Optional Feature:
SPI_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES without spi_done: spi_data_len <= 0, state <= GAP, req_done[grant_id] pulses with req_timeout=1 in the same cycle.
  - spi_done and the timeout in the same cycle: spi_done wins, req_timeout=0.
- Undefined: no counter; RUN waits indefinitely; req_timeout is tied to 0.

Test Plan:
- Single write: req0 wnr=1, addr=0x155, len=40 -> ack0 in the same cycle; next cycle WnR=1, spi_address=0x155, spi_data_len=40. spi_done at cycle N -> spi_data_len=0 and req_done[0]=1 at N+1; busy low at N+2.
- Contention: req0 and req1 valid continuously, 4 transactions -> grant order 0,1,0,1; req_ack never two-hot.
- Zero length: req1 len=0 -> ack1, spi_data_len stays 0, req_done[1] pulses 1 cycle later, then the next request is served.
- Stray done: spi_done pulsed in IDLE and GAP -> no req_done, no state change.
- Reset mid-RUN (len=200 active): reset_b low -> spi_data_len=0 immediately, no req_done; after release, req0 wins first.
- SPI_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16, spi_done never pulsed -> at RUN cycle 16, spi_data_len=0 and req_done[i]=1 with req_timeout=1. Repeat with spi_done in cycle 16 -> req_timeout=0.
